// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and helpers for the ccff chain loader.
// Holds the loader FSM state encoding and final-word sizing.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    // Valid bits carried in the MSBs of the last word of a pass.
    function automatic int last_word_bits(input int chain_len,
                                          input int data_w);
        int rem;
        rem = chain_len % data_w;
        return (rem == 0) ? data_w : rem;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: parallel-in / serial-out word shifter, MSB first.
// bit_o is the register MSB, so the serial output is registered.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o,
    output logic              word_empty_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Load a fresh word or advance one bit toward the MSB.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = data_i;
            cnt_d  = CW'(DATA_W);
        end else if (shift_i && (cnt_q != '0)) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q - CW'(1);
        end
    end

    // Shifter and remaining-bit count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_o        = sreg_q[DATA_W-1];
    // No bits remain after the one currently on bit_o.
    assign word_empty_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams host words MSB-first into a ccff scan chain.
// Optional tail readback compare is built with CCFF_LOADER_VERIFY_EN.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 52,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             clk_en_q;
    logic             word_empty;
    logic             ser_load;
    logic             ser_shift;
    logic             last_bit;
    logic             start_acc;

    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign start_acc = (state_q == IDLE) && start;

    ccff_word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk_i        (prog_clk),
        .rst_i        (pReset),
        .load_i       (ser_load),
        .shift_i      (ser_shift),
        .data_i       (s_data),
        .bit_o        (ccff_head),
        .word_empty_o (word_empty)
    );

    // FSM state register.
    always_ff @(posedge prog_clk) begin
        if (pReset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  if (s_valid) state_d = SHIFT;
            SHIFT: begin
                if (last_bit)                    state_d = DONE;
                else if (word_empty && !s_valid) state_d = LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, shifter control and status.
    always_comb begin
        s_ready   = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            LOAD: begin
                busy     = 1'b1;
                s_ready  = 1'b1;
                ser_load = s_valid;
            end
            SHIFT: begin
                busy      = 1'b1;
                s_ready   = word_empty && !last_bit;
                ser_load  = word_empty && !last_bit && s_valid;
                ser_shift = !(word_empty && !last_bit && s_valid);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Bit counter and registered chain shift enable.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bit_cnt_q <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            clk_en_q <= (state_d == SHIFT);
            if (start_acc)               bit_cnt_q <= '0;
            else if (state_q == SHIFT)   bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
    end

    assign ccff_clk_en = clk_en_q;

`ifdef CCFF_LOADER_VERIFY_EN
    logic verify_q;
    logic error_q;

    // Sticky tail-vs-head compare on every enabled bit of a verify pass.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            verify_q <= 1'b0;
            error_q  <= 1'b0;
        end else if (start_acc) begin
            verify_q <= verify;
            error_q  <= 1'b0;
        end else if (verify_q && clk_en_q && (ccff_tail != ccff_head)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic unused_verify;
    assign unused_verify = verify ^ ccff_tail;
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench for ccff_chain_loader.
// Models the 52-bit chain and checks ordering, timing and verify.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 52;
    localparam int DATA_W    = 8;
    localparam int NWORDS    = 7;
    localparam int TMO       = 300;
    localparam logic [51:0] EXP_CHAIN  = 52'hA53CF0965AC33;
    localparam logic [51:0] FLIP_CHAIN = 52'hA53CB0965AC33;

    logic        prog_clk = 1'b0;
    logic        pReset   = 1'b1;
    logic        start    = 1'b0;
    logic        verify   = 1'b0;
    logic        s_valid  = 1'b0;
    logic [7:0]  s_data   = 8'h00;
    logic        s_ready, ccff_head, ccff_clk_en, ccff_tail;
    logic        busy, done, error;

    logic [7:0]  words [NWORDS] = '{8'hA5, 8'h3C, 8'hF0, 8'h96,
                                    8'h5A, 8'hC3, 8'h3F};
    logic [51:0] chain = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int en_cnt, first_en, last_en, done_cnt, done_cyc, err_rise;
    int start_cyc;
    bit busy_at_done;
    bit abort_host = 1'b0;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .DATA_W    (DATA_W)
    ) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .verify      (verify),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: captures head on every enabled edge.
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    assign ccff_tail = chain[CHAIN_LEN-1];

    // Pass monitor sampled on the falling edge.
    always @(negedge prog_clk) begin
        if (ccff_clk_en) begin
            if (en_cnt == 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (error && err_rise < 0) err_rise = cyc;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic begin_pass(input logic v);
        @(negedge prog_clk);
        en_cnt     = 0;
        done_cnt   = 0;
        first_en   = -1;
        last_en    = -1;
        done_cyc   = -1;
        err_rise   = -1;
        abort_host = 1'b0;
        start      = 1'b1;
        verify     = v;
        start_cyc  = cyc;
        @(negedge prog_clk);
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic stream(input logic [7:0] flip_mask, input int flip_word,
                          input int stall_word, input int stall_len);
        for (int i = 0; i < NWORDS; i++) begin
            int t;
            if (i == stall_word) begin
                s_valid = 1'b0;
                t = 0;
                while (!s_ready && t < TMO && !abort_host) begin
                    @(negedge prog_clk);
                    t++;
                end
                if (t >= TMO) check("stall_wait_tmo", 0, 1);
                repeat (stall_len) @(negedge prog_clk);
            end
            s_data  = words[i] ^ ((i == flip_word) ? flip_mask : 8'h00);
            s_valid = 1'b1;
            t = 0;
            while (!s_ready && t < TMO && !abort_host) begin
                @(negedge prog_clk);
                t++;
            end
            if (abort_host) break;
            if (t >= TMO) begin
                check("hs_wait_tmo", 0, 1);
                break;
            end
            @(negedge prog_clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt == 0 && t < TMO) begin
            @(negedge prog_clk);
            #1;
            t++;
        end
        if (done_cnt == 0) check(tag, 0, 1);
        repeat (2) @(negedge prog_clk);
    endtask

    task automatic check_pass(input string tag, input int gap,
                              input logic [51:0] exp_chain);
        check({tag, " bits"}, en_cnt, CHAIN_LEN);
        check({tag, " first"}, first_en - start_cyc, 2);
        check({tag, " span"}, last_en - first_en + 1, CHAIN_LEN + gap);
        check({tag, " done_at"}, done_cyc - start_cyc, CHAIN_LEN + 2 + gap);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " busy_at_done"}, busy_at_done, 0);
        check({tag, " chain"}, chain, exp_chain);
    endtask

    initial begin
        en_cnt   = 0;
        done_cnt = 0;
        err_rise = -1;
        repeat (3) @(negedge prog_clk);
        check("rst s_ready", s_ready, 0);
        check("rst head", ccff_head, 0);
        check("rst clk_en", ccff_clk_en, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        pReset = 1'b0;

        @(negedge prog_clk);
        en_cnt  = 0;
        s_data  = 8'hFF;
        s_valid = 1'b1;
        repeat (5) @(negedge prog_clk);
        check("idle s_ready", s_ready, 0);
        check("idle no_shift", en_cnt, 0);
        check("idle busy", busy, 0);
        s_valid = 1'b0;

        begin_pass(1'b0);
        stream(8'h00, -1, -1, 0);
        wait_done("full done_tmo");
        check_pass("full", 0, EXP_CHAIN);

        begin_pass(1'b0);
        stream(8'h00, -1, 2, 5);
        wait_done("stall done_tmo");
        check_pass("stall", 5, EXP_CHAIN);

`ifdef CCFF_LOADER_VERIFY_EN
        begin_pass(1'b1);
        stream(8'h00, -1, -1, 0);
        wait_done("vfy_ok done_tmo");
        check_pass("vfy_ok", 0, EXP_CHAIN);
        check("vfy_ok error", error, 0);

        begin_pass(1'b1);
        stream(8'h40, 2, -1, 0);
        wait_done("vfy_bad done_tmo");
        check_pass("vfy_bad", 0, FLIP_CHAIN);
        check("vfy_bad rise", err_rise - start_cyc, 20);
        check("vfy_bad sticky", error, 1);

        begin_pass(1'b0);
        check("vfy clear_on_start", error, 0);
        stream(8'h00, -1, -1, 0);
        wait_done("vfy_clr done_tmo");
        check_pass("vfy_clr", 0, EXP_CHAIN);
`else
        begin_pass(1'b1);
        stream(8'h40, 2, -1, 0);
        wait_done("novfy done_tmo");
        check_pass("novfy", 0, FLIP_CHAIN);
        check("novfy error", error, 0);
`endif

        begin_pass(1'b0);
        fork
            stream(8'h00, -1, -1, 0);
            begin
                int t;
                t = 0;
                while (en_cnt < 30 && t < TMO) begin
                    @(negedge prog_clk);
                    #1;
                    t++;
                end
                if (t >= TMO) check("rst_mid wait_tmo", 0, 1);
                pReset     = 1'b1;
                abort_host = 1'b1;
                @(negedge prog_clk);
                check("rst_mid clk_en", ccff_clk_en, 0);
                check("rst_mid busy", busy, 0);
                check("rst_mid s_ready", s_ready, 0);
                pReset = 1'b0;
            end
        join
        repeat (60) @(negedge prog_clk);
        check("rst_mid no_done", done_cnt, 0);
        check("rst_mid bits", en_cnt, 30);

        begin_pass(1'b0);
        stream(8'h00, -1, -1, 0);
        wait_done("reload done_tmo");
        check_pass("reload", 0, EXP_CHAIN);

        begin_pass(1'b0);
        fork
            stream(8'h00, -1, -1, 0);
            begin
                int t;
                t = 0;
                while (en_cnt < 10 && t < TMO) begin
                    @(negedge prog_clk);
                    t++;
                end
                if (t >= TMO) check("busy_start wait_tmo", 0, 1);
                @(negedge prog_clk);
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
        join
        wait_done("busy_start done_tmo");
        check_pass("busy_start", 0, EXP_CHAIN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
